// File: rtl/branch_resolution_tracker_if.sv
// Fetch/execute/predictor-update signal bundle for branch_resolution_tracker.
// The master side drives fetch and resolve requests; the slave side is the tracker.
interface branch_resolution_tracker_if #(
    parameter int DEPTH     = 4,
    parameter int WORD_SIZE = 32
);
    logic                       fetch_valid;
    logic                       fetch_ready;
    logic [WORD_SIZE-1:0]       fetch_pc;
    logic                       fetch_pred_taken;
    logic [WORD_SIZE-1:0]       fetch_pred_target;
    logic                       ex_resolve_valid;
    logic [WORD_SIZE-1:0]       ex_pc;
    logic                       ex_taken;
    logic [WORD_SIZE-1:0]       ex_target;
    logic                       flush_in;
    logic                       mispredict;
    logic [WORD_SIZE-1:0]       redirect_pc;
    logic                       update_valid;
    logic [WORD_SIZE-1:0]       update_pc;
    logic                       update_taken;
    logic [WORD_SIZE-1:0]       update_target;
    logic                       protocol_err;
    logic [$clog2(DEPTH):0]     occupancy;

    modport master (
        output fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
        output ex_resolve_valid, ex_pc, ex_taken, ex_target, flush_in,
        input  fetch_ready, mispredict, redirect_pc, update_valid, update_pc,
        input  update_taken, update_target, protocol_err, occupancy
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
        input  ex_resolve_valid, ex_pc, ex_taken, ex_target, flush_in,
        output fetch_ready, mispredict, redirect_pc, update_valid, update_pc,
        output update_taken, update_target, protocol_err, occupancy
    );
endinterface

// File: rtl/branch_resolution_tracker.sv
// In-order record of fetch-time branch predictions, checked against execute resolutions.
// Define BR_RESOLVE_PERF_EN to add saturating branch_count / mispredict_count outputs.
module branch_resolution_tracker #(
    parameter int DEPTH     = 4,
    parameter int WORD_SIZE = 32
) (
    input  logic                         CLK,
    input  logic                         nRST,
    branch_resolution_tracker_if.slave   bus
`ifdef BR_RESOLVE_PERF_EN
    ,
    output logic [31:0]                  branch_count,
    output logic [31:0]                  mispredict_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic                 pred_taken;
        logic [WORD_SIZE-1:0] pred_target;
    } rec_t;

    rec_t                 mem_q [DEPTH];
    rec_t                 mem_d [DEPTH];
    logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 mispredict_q, mispredict_d;
    logic [WORD_SIZE-1:0] redirect_pc_q, redirect_pc_d;
    logic                 update_valid_q, update_valid_d;
    logic [WORD_SIZE-1:0] update_pc_q, update_pc_d;
    logic                 update_taken_q, update_taken_d;
    logic [WORD_SIZE-1:0] update_target_q, update_target_d;
    logic                 protocol_err_q, protocol_err_d;

    logic                 fetch_ready_s;
    logic                 push_s, resolve_s, pop_s, mis_s;
    rec_t                 head_rec_s;

    assign fetch_ready_s = (count_q < CW'(DEPTH));
    assign head_rec_s    = mem_q[head_q];

    // Decode this cycle's events; flush outranks resolve, which outranks push.
    always_comb begin
        resolve_s = bus.ex_resolve_valid && !bus.flush_in;
        pop_s     = resolve_s && (count_q != CW'(0));
        push_s    = bus.fetch_valid && fetch_ready_s && !bus.flush_in;
        if (pop_s) begin
            mis_s = (head_rec_s.pred_taken != bus.ex_taken) ||
                    (bus.ex_taken && (head_rec_s.pred_target != bus.ex_target)) ||
                    (head_rec_s.pc != bus.ex_pc);
        end else begin
            mis_s = 1'b0;
        end
    end

    // Next-state for FIFO bookkeeping and the registered resolve outputs.
    always_comb begin
        mem_d           = mem_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        mispredict_d    = 1'b0;
        update_valid_d  = 1'b0;
        protocol_err_d  = 1'b0;
        redirect_pc_d   = redirect_pc_q;
        update_pc_d     = update_pc_q;
        update_taken_d  = update_taken_q;
        update_target_d = update_target_q;

        if (bus.flush_in || mis_s) begin
            // Everything younger than a mispredicted branch is wrong-path.
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_d[tail_q] = '{pc: bus.fetch_pc, pred_taken: bus.fetch_pred_taken,
                                  pred_target: bus.fetch_pred_target};
                tail_d = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (pop_s) begin
            update_valid_d  = 1'b1;
            update_pc_d     = bus.ex_pc;
            update_taken_d  = bus.ex_taken;
            update_target_d = bus.ex_target;
            mispredict_d    = mis_s;
            redirect_pc_d   = bus.ex_taken ? bus.ex_target : (bus.ex_pc + WORD_SIZE'(4));
        end else begin
            protocol_err_d = resolve_s;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q          <= {PW{1'b0}};
            tail_q          <= {PW{1'b0}};
            count_q         <= {CW{1'b0}};
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= {WORD_SIZE{1'b0}};
            update_valid_q  <= 1'b0;
            update_pc_q     <= {WORD_SIZE{1'b0}};
            update_taken_q  <= 1'b0;
            update_target_q <= {WORD_SIZE{1'b0}};
            protocol_err_q  <= 1'b0;
        end else begin
            mem_q           <= mem_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            mispredict_q    <= mispredict_d;
            redirect_pc_q   <= redirect_pc_d;
            update_valid_q  <= update_valid_d;
            update_pc_q     <= update_pc_d;
            update_taken_q  <= update_taken_d;
            update_target_q <= update_target_d;
            protocol_err_q  <= protocol_err_d;
        end
    end

    assign bus.fetch_ready   = fetch_ready_s;
    assign bus.occupancy     = count_q;
    assign bus.mispredict    = mispredict_q;
    assign bus.redirect_pc   = redirect_pc_q;
    assign bus.update_valid  = update_valid_q;
    assign bus.update_pc     = update_pc_q;
    assign bus.update_taken  = update_taken_q;
    assign bus.update_target = update_target_q;
    assign bus.protocol_err  = protocol_err_q;

`ifdef BR_RESOLVE_PERF_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    // Saturating event counters, stepped on the same edge that raises the pulses.
    always_comb begin
        if (pop_s && (branch_count_q != 32'hFFFF_FFFF)) begin
            branch_count_d = branch_count_q + 32'd1;
        end else begin
            branch_count_d = branch_count_q;
        end
        if (mis_s && (mispredict_count_q != 32'hFFFF_FFFF)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end else begin
            mispredict_count_d = mispredict_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`endif
endmodule
